mc_control: RTL
===============

# mc_control

Multicycle control unit for the ARM-subset core: a single state machine plus instruction decoder that sequences fetch, decode, memory, ALU, branch and variable-latency execute operations (iterative multiply, FPU). It generalises the fixed-latency controller with a start/done handshake to long-latency units, a cycle-bounded timeout, a CMP path with no register write, a parametrised ALUControl width, and a sticky FAULT state for undefined encodings. It sits between the instruction register and the datapath muxes and write enables.

## Interface
- ALU_W, 4: ALUControl width; must be ≥ 4.
- TIMEOUT, 64: max XWAIT cycles before FAULT; ≥ 1.
- HAS_FPU, 1: 1 enables Op=11 FPU path; 0 makes Op=11 undefined.

- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high.
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20].
- Rd  in  4  Instr[15:12].
- Mul  in  4  Instr[7:4]; 4'b1001 marks a multiply.
- XDone  in  1  long-op unit result valid.
- IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, PCS  out  1 each  datapath strobes/selects.
- ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  datapath mux selects.
- FlagW  out  2  [1]=NZ write, [0]=CV write.
- ALUControl  out  ALU_W  operation code.
- XStart  out  1  one-cycle start pulse to long-op unit.
- XSel  out  1  0=multiplier, 1=FPU; stable through XWAIT/XWB.
- Fault  out  1  high while in FAULT.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, XWAIT, XWB, FAULT.
- Outputs are combinational from state + Op/Funct/Mul; unlisted outputs 0.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1. DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01. MEMRD: AdrSrc=1. MEMWB: ResultSrc=01, RegW=1. MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUSrcB=00, ALU decode active. EXECI: ALUSrcB=01, ALU decode active. ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1. XWAIT: long-op decode active. XWB: ResultSrc=11; RegW=1 if XSel=0, FPUW=1 if XSel=1.
- DECODE → (first match): ALU/long-op decode undefined → FAULT; Op=01 → MEMADR; Op=00 & Mul=1001 → XWAIT (XSel=0); Op=11 & HAS_FPU → XWAIT (XSel=1); Op=11 & !HAS_FPU → FAULT; Op=00 & Funct[5] → EXECI; Op=00 → EXECR; Op=10 → BRANCH.
- MEMADR → MEMRD if Funct[0] else MEMWR; MEMRD → MEMWB → FETCH; MEMWR → FETCH; BRANCH → FETCH; XWB → FETCH.
- EXECR/EXECI → FETCH if CMP, else ALUWB → FETCH.
- ALU decode (Funct[4:1]): 0100 ADD=0, 0010 SUB=1, 0000 AND=2, 1100 ORR=3, 0001 EOR=4, 1010 CMP=1 (forced S); other → undefined.
- Mul decode: 0000 MUL=5, 0100 UMULL=6, 0110 SMULL=7. FPU decode: 0000 FADD=8, 0001 FMUL=9. Others undefined. Codes zero-extended to ALU_W; ALUControl=0 outside decode states.
- FlagW in EXECR/EXECI: [1]=S, [0]=S & (ADD|SUB|CMP); CMP → 11. In XWB with XSel=0: [1]=Funct[0], [0]=0. Elsewhere 00.
- PCS = Branch | (RegW & Rd==4'hF); FPUW never raises PCS.
- ImmSrc=Op; RegSrc[1]=(Op==01); RegSrc[0]=(Op==10).
- FAULT: sticky; all writes/strobes 0; exit only by reset.

## Timing
- reset high at a clk edge → state=FETCH, XWAIT counter=0, XSel=0; holds every edge while reset high. Reset mid-XWAIT aborts; no XStart re-issued.
- XStart high only on the first XWAIT cycle. XDone sampled every XWAIT cycle, including the first.
- XWAIT cycle index k=0..TIMEOUT-1; XDone at k → XWB next. No XDone by k=TIMEOUT-1 → FAULT next. Counter width $clog2(TIMEOUT+1).
- XDone outside XWAIT ignored.
- Latencies (cycles from FETCH to next FETCH): B 3, CMP 3, ADD/STR 4, LDR 5, long-op 4+k.

## Structure
- ctrl_pkg: state enum, Op encodings, ALUControl code constants, MUL_IND=4'b1001.
- Sub-module alu_dec: combinational ALU/Mul/FPU decoder → ALUControl, FlagW, undefined flag. FSM and counter live in mc_control.

## Test plan
- ADD R1,R2,R3, S=1 (Op=00, Funct=001001): FETCH→DECODE→EXECR→ALUWB; ALUControl=0, FlagW=11, RegW only in ALUWB.
- CMP (Funct=110101): 3 cycles, FlagW=11, ALUControl=1, RegW never high.
- LDR to Rd=15 (Op=01, Funct[0]=1): 5-state path; PCS=1 in MEMWB; STR: MemW=1 in MEMWR only.
- MUL (Mul=1001, Funct[4:1]=0000), XDone at k=3: one XStart pulse, ALUControl=5, XWB then FETCH, RegW=1 in XWB.
- TIMEOUT=4, FPU op, XDone never: FAULT after 4 XWAIT cycles, Fault=1 held; reset → FETCH.
- HAS_FPU=0, Op=11 → FAULT from DECODE; ALU Funct[4:1]=0111 → FAULT; reset during XWAIT → FETCH, XStart=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_XWAIT,
    S_XWB,
    S_FAULT
  } state_e;

  // Instr[27:26] classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_FP  = 2'b11;

  // Instr[7:4] pattern marking a multiply
  localparam logic [3:0] MUL_IND = 4'b1001;

  // ALUControl codes (zero-extended to ALU_W at the port)
  localparam logic [3:0] ALUC_ADD   = 4'd0;
  localparam logic [3:0] ALUC_SUB   = 4'd1;
  localparam logic [3:0] ALUC_AND   = 4'd2;
  localparam logic [3:0] ALUC_ORR   = 4'd3;
  localparam logic [3:0] ALUC_EOR   = 4'd4;
  localparam logic [3:0] ALUC_MUL   = 4'd5;
  localparam logic [3:0] ALUC_UMULL = 4'd6;
  localparam logic [3:0] ALUC_SMULL = 4'd7;
  localparam logic [3:0] ALUC_FADD  = 4'd8;
  localparam logic [3:0] ALUC_FMUL  = 4'd9;

  // Funct[4:1] encodings for data-processing ops
  localparam logic [3:0] F_ADD = 4'b0100;
  localparam logic [3:0] F_SUB = 4'b0010;
  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_ORR = 4'b1100;
  localparam logic [3:0] F_EOR = 4'b0001;
  localparam logic [3:0] F_CMP = 4'b1010;

  // Funct[4:1] encodings for multiply and FPU ops
  localparam logic [3:0] M_MUL   = 4'b0000;
  localparam logic [3:0] M_UMULL = 4'b0100;
  localparam logic [3:0] M_SMULL = 4'b0110;
  localparam logic [3:0] FP_FADD = 4'b0000;
  localparam logic [3:0] FP_FMUL = 4'b0001;

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU / multiply / FPU decoder: operation code, flag writes, undefined flag.
module alu_dec
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_W   = 4,
  parameter int unsigned HAS_FPU = 1
) (
  input  logic [1:0]       i_op,
  input  logic [4:0]       i_funct,
  input  logic [3:0]       i_mul,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic [1:0]       o_flag_w,
  output logic             o_is_cmp,
  output logic             o_undef
);

  logic [3:0] w_code;
  logic       w_arith;
  logic       w_s;

  assign w_s = i_funct[0];

  // Decode Funct[4:1] according to the instruction class
  always_comb begin
    w_code   = ALUC_ADD;
    w_arith  = 1'b0;
    o_is_cmp = 1'b0;
    o_undef  = 1'b0;
    case (i_op)
      OP_DP: begin
        if (i_mul == MUL_IND) begin
          case (i_funct[4:1])
            M_MUL:   w_code = ALUC_MUL;
            M_UMULL: w_code = ALUC_UMULL;
            M_SMULL: w_code = ALUC_SMULL;
            default: o_undef = 1'b1;
          endcase
        end else begin
          case (i_funct[4:1])
            F_ADD: begin
              w_code  = ALUC_ADD;
              w_arith = 1'b1;
            end
            F_SUB: begin
              w_code  = ALUC_SUB;
              w_arith = 1'b1;
            end
            F_AND:   w_code = ALUC_AND;
            F_ORR:   w_code = ALUC_ORR;
            F_EOR:   w_code = ALUC_EOR;
            F_CMP: begin
              w_code   = ALUC_SUB;
              o_is_cmp = 1'b1;
            end
            default: o_undef = 1'b1;
          endcase
        end
      end
      OP_FP: begin
        if (HAS_FPU != 0) begin
          case (i_funct[4:1])
            FP_FADD: w_code = ALUC_FADD;
            FP_FMUL: w_code = ALUC_FMUL;
            default: o_undef = 1'b1;
          endcase
        end else begin
          o_undef = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_alu_ctrl = ALU_W'(w_code);
  // CMP always updates all flags; otherwise S gates NZ, and CV only for arithmetic
  assign o_flag_w   = o_is_cmp ? 2'b11 : {w_s, w_s & w_arith};

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM with start/done handshake to long-latency units.
module mc_control
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_W   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned HAS_FPU = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic [3:0]       Rd,
  input  logic [3:0]       Mul,
  input  logic             XDone,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             FPUW,
  output logic             Branch,
  output logic             PCS,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ImmSrc,
  output logic [1:0]       RegSrc,
  output logic [1:0]       FlagW,
  output logic [ALU_W-1:0] ALUControl,
  output logic             XStart,
  output logic             XSel,
  output logic             Fault
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] XLAST = CW'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [CW-1:0]    r_xcnt;
  logic             r_xsel;
  logic [ALU_W-1:0] w_alu_ctrl;
  logic [1:0]       w_flag_w;
  logic             w_is_cmp;
  logic             w_undef;

  alu_dec #(
    .ALU_W   (ALU_W),
    .HAS_FPU (HAS_FPU)
  ) u_alu_dec (
    .i_op       (Op),
    .i_funct    (Funct[4:0]),
    .i_mul      (Mul),
    .o_alu_ctrl (w_alu_ctrl),
    .o_flag_w   (w_flag_w),
    .o_is_cmp   (w_is_cmp),
    .o_undef    (w_undef)
  );

  assign XSel = r_xsel;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  // XWAIT cycle index and long-op unit select, latched on entry to XWAIT
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xcnt <= '0;
      r_xsel <= 1'b0;
    end else begin
      if (r_state == S_XWAIT && w_next_state == S_XWAIT) r_xcnt <= r_xcnt + CW'(1);
      else                                               r_xcnt <= '0;
      if (r_state == S_DECODE && w_next_state == S_XWAIT) r_xsel <= (Op == OP_FP);
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_next_state = r_state;
    IRWrite      = 1'b0;
    AdrSrc       = 1'b0;
    NextPC       = 1'b0;
    RegW         = 1'b0;
    MemW         = 1'b0;
    FPUW         = 1'b0;
    Branch       = 1'b0;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ResultSrc    = 2'b00;
    FlagW        = 2'b00;
    ALUControl   = '0;
    XStart       = 1'b0;
    Fault        = 1'b0;
    ImmSrc       = Op;
    RegSrc       = {(Op == OP_MEM), (Op == OP_BR)};
    case (r_state)
      S_FETCH: begin
        IRWrite      = 1'b1;
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        NextPC       = 1'b1;
        w_next_state = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (w_undef)                                w_next_state = S_FAULT;
        else if (Op == OP_MEM)                      w_next_state = S_MEMADR;
        else if (Op == OP_DP && Mul == MUL_IND)     w_next_state = S_XWAIT;
        else if (Op == OP_FP)                       w_next_state = S_XWAIT;
        else if (Op == OP_DP && Funct[5])           w_next_state = S_EXECI;
        else if (Op == OP_DP)                       w_next_state = S_EXECR;
        else                                        w_next_state = S_BRANCH;
      end
      S_MEMADR: begin
        ALUSrcB      = 2'b01;
        w_next_state = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc       = 1'b1;
        w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        RegW         = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc       = 1'b1;
        MemW         = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB      = (r_state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl   = w_alu_ctrl;
        FlagW        = w_flag_w;
        w_next_state = w_is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        RegW         = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB      = 2'b01;
        ResultSrc    = 2'b10;
        Branch       = 1'b1;
        w_next_state = S_FETCH;
      end
      S_XWAIT: begin
        ALUControl = w_alu_ctrl;
        XStart     = (r_xcnt == '0);
        if (XDone)                w_next_state = S_XWB;
        else if (r_xcnt == XLAST) w_next_state = S_FAULT;
        else                      w_next_state = S_XWAIT;
      end
      S_XWB: begin
        ResultSrc = 2'b11;
        if (r_xsel) begin
          FPUW = 1'b1;
        end else begin
          RegW  = 1'b1;
          FlagW = {Funct[0], 1'b0};
        end
        w_next_state = S_FETCH;
      end
      S_FAULT: begin
        Fault        = 1'b1;
        w_next_state = S_FAULT;
      end
      default: w_next_state = S_FAULT;
    endcase
    // FPU results go to the FP register file, so only integer writes redirect the PC
    PCS = Branch | (RegW & (Rd == 4'hF));
  end

endmodule
